// File: rtl/svm_seq_pkg.sv
// Shared types and sizing helpers for the sequential multi-class SVM classifier.
// Mode encoding matches the in_mode pin: 0 = one-vs-one voting, 1 = one-vs-rest argmax.
package svm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        MODE_OVO = 1'b0,
        MODE_OVR = 1'b1
    } mode_t;

    function automatic int n_ovo(input int n);
        return n * (n - 1) / 2;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/svm_dot_engine.sv
// Combinational signed dot product of unsigned features with signed weights, plus a
// sign-extended bias, evaluated at SCORE_W bits of signed arithmetic.
module svm_dot_engine #(
    parameter int N_FEATURES = 11,
    parameter int INPUT_W    = 4,
    parameter int WEIGHT_W   = 8,
    parameter int BIAS_W     = 12,
    parameter int SCORE_W    = 18
) (
    input  logic [N_FEATURES*INPUT_W-1:0]  features,
    input  logic [N_FEATURES*WEIGHT_W-1:0] weights,
    input  logic [BIAS_W-1:0]              bias,
    output logic signed [SCORE_W-1:0]      score
);

    logic signed [SCORE_W-1:0] acc;
    logic signed [SCORE_W-1:0] x_ext;
    logic signed [SCORE_W-1:0] w_ext;

    // Features are zero-extended, weights and bias sign-extended, before the multiply.
    always_comb begin
        acc   = {{(SCORE_W-BIAS_W){bias[BIAS_W-1]}}, bias};
        x_ext = '0;
        w_ext = '0;
        for (int f = 0; f < N_FEATURES; f++) begin
            x_ext = {{(SCORE_W-INPUT_W){1'b0}}, features[f*INPUT_W +: INPUT_W]};
            w_ext = {{(SCORE_W-WEIGHT_W){weights[f*WEIGHT_W+WEIGHT_W-1]}},
                     weights[f*WEIGHT_W +: WEIGHT_W]};
            acc   = acc + x_ext * w_ext;
        end
        score = acc;
    end

endmodule

// File: rtl/svm_multiclass_seq.sv
// Sequential multi-class SVM: one shared dot-product engine stepped over every
// sub-classifier, with one-vs-one voting or one-vs-rest argmax chosen per request.
module svm_multiclass_seq
    import svm_seq_pkg::*;
#(
    parameter int  N_CLASSES  = 6,
    parameter int  N_FEATURES = 11,
    parameter int  INPUT_W    = 4,
    parameter int  WEIGHT_W   = 8,
    parameter int  BIAS_W     = 12,
    localparam int N_OVO      = n_ovo(N_CLASSES),
    localparam int IDX_W      = clog2_min1(N_OVO),
    localparam int CLS_W      = clog2_min1(N_CLASSES),
    localparam int SCORE_W    = INPUT_W + WEIGHT_W + $clog2(N_FEATURES) + 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_mode,
    input  logic [INPUT_W*N_FEATURES-1:0]  in,
    output logic [IDX_W-1:0]               coef_idx,
    input  logic [WEIGHT_W*N_FEATURES-1:0] coef_w,
    input  logic [BIAS_W-1:0]              coef_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CLS_W-1:0]               out_class,
    output logic [SCORE_W-1:0]             out_score
);

    state_t                          state, state_next;
    mode_t                           mode_q;
    logic [INPUT_W*N_FEATURES-1:0]   feat_q;
    logic [IDX_W-1:0]                k, k_last;
    logic [CLS_W-1:0]                pair_i, pair_j;
    logic [CLS_W-1:0]                votes [N_CLASSES];
    logic signed [SCORE_W-1:0]       score, best_score;
    logic [CLS_W-1:0]                best_cls;
    logic [CLS_W-1:0]                ovo_cls, ovo_max;
    logic [CLS_W-1:0]                out_class_q;
    logic [SCORE_W-1:0]              out_score_q;
    logic                            accept, release_res;

    svm_dot_engine #(
        .N_FEATURES (N_FEATURES),
        .INPUT_W    (INPUT_W),
        .WEIGHT_W   (WEIGHT_W),
        .BIAS_W     (BIAS_W),
        .SCORE_W    (SCORE_W)
    ) u_dot (
        .features (feat_q),
        .weights  (coef_w),
        .bias     (coef_b),
        .score    (score)
    );

    // Handshake: a transfer happens on a rising clk edge where valid && ready are both
    // high; in_ready only in IDLE, out_valid only in DONE, both forced low during rst.
    assign in_ready    = (state == IDLE) && !rst;
    assign out_valid   = (state == DONE) && !rst;
    assign accept      = in_valid && in_ready;
    assign release_res = out_valid && out_ready;
    assign coef_idx    = rst ? '0 : k;
    assign out_class   = rst ? '0 : out_class_q;
    assign out_score   = rst ? '0 : out_score_q;

    assign k_last = (mode_q == MODE_OVO) ? IDX_W'(N_OVO - 1) : IDX_W'(N_CLASSES - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = EVAL;
            EVAL:    if (k == k_last) state_next = DECIDE;
            DECIDE:                   state_next = DONE;
            DONE:    if (release_res) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // Vote argmax with strict compare so the lowest class index wins ties.
    always_comb begin
        ovo_cls = '0;
        ovo_max = votes[0];
        for (int c = 1; c < N_CLASSES; c++) begin
            if (votes[c] > ovo_max) begin
                ovo_max = votes[c];
                ovo_cls = CLS_W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_OVO;
            feat_q      <= '0;
            k           <= '0;
            pair_i      <= '0;
            pair_j      <= '0;
            best_score  <= '0;
            best_cls    <= '0;
            out_class_q <= '0;
            out_score_q <= '0;
            for (int c = 0; c < N_CLASSES; c++) votes[c] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q     <= mode_t'(in_mode);
                        feat_q     <= in;
                        k          <= '0;
                        pair_i     <= '0;
                        pair_j     <= CLS_W'(1);
                        best_score <= '0;
                        best_cls   <= '0;
                        for (int c = 0; c < N_CLASSES; c++) votes[c] <= '0;
                    end
                end
                EVAL: begin
                    k <= (k == k_last) ? '0 : k + IDX_W'(1);
                    if (mode_q == MODE_OVO) begin
                        if (!score[SCORE_W-1]) votes[pair_i] <= votes[pair_i] + CLS_W'(1);
                        else                   votes[pair_j] <= votes[pair_j] + CLS_W'(1);
                        // Lexicographic pair walk: (0,1),(0,2)..(0,N-1),(1,2)..
                        if (pair_j == CLS_W'(N_CLASSES - 1)) begin
                            pair_i <= pair_i + CLS_W'(1);
                            pair_j <= pair_i + CLS_W'(2);
                        end else begin
                            pair_j <= pair_j + CLS_W'(1);
                        end
                    end else if (k == '0 || score > best_score) begin
                        best_score <= score;
                        best_cls   <= CLS_W'(k);
                    end
                end
                DECIDE: begin
                    if (mode_q == MODE_OVO) begin
                        out_class_q <= ovo_cls;
                        out_score_q <= SCORE_W'(ovo_max);
                    end else begin
                        out_class_q <= best_cls;
                        out_score_q <= best_score;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_svm_multiclass_seq.sv
// Directed bench for svm_multiclass_seq with 3 classes and 2 features; the coefficient
// store is a small table indexed combinationally by coef_idx.
module tb_svm_multiclass_seq;

    localparam int NC = 3, NF = 2, IW = 4, WW = 8, BW = 12;
    localparam int IDXW = 2, CLSW = 2, SW = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_mode = 1'b0;
    logic [IW*NF-1:0] in_feat = '0;
    logic [IDXW-1:0] coef_idx;
    logic [WW*NF-1:0] coef_w;
    logic [BW-1:0]   coef_b;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [CLSW-1:0] out_class;
    logic [SW-1:0]   out_score;

    logic [WW-1:0]   w_tab [4][NF];
    logic [BW-1:0]   b_tab [4];

    int checks = 0;
    int errors = 0;
    int lat;

    svm_multiclass_seq #(
        .N_CLASSES  (NC),
        .N_FEATURES (NF),
        .INPUT_W    (IW),
        .WEIGHT_W   (WW),
        .BIAS_W     (BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in        (in_feat),
        .coef_idx  (coef_idx),
        .coef_w    (coef_w),
        .coef_b    (coef_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_score (out_score)
    );

    always #5 clk = ~clk;

    always_comb begin
        coef_w = {w_tab[coef_idx][1], w_tab[coef_idx][0]};
        coef_b = b_tab[coef_idx];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sc(input int s);
        return 32'(s) & 32'h7fff;
    endfunction

    task automatic set_w(input int w0, input int w1);
        for (int c = 0; c < 4; c++) begin
            w_tab[c][0] = 8'(w0);
            w_tab[c][1] = 8'(w1);
        end
    endtask

    task automatic set_b(input int b0, input int b1, input int b2);
        b_tab[0] = 12'(b0);
        b_tab[1] = 12'(b1);
        b_tab[2] = 12'(b2);
        b_tab[3] = '0;
    endtask

    task automatic send(input logic mode, input int f0, input int f1);
        in_mode  = mode;
        in_feat  = {4'(f1), 4'(f0)};
        in_valid = 1'b1;
        check("req_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Bounded wait: lat counts cycles from the accept cycle, so first DONE cycle = K+2.
    task automatic wait_valid(output int l);
        l = 1;
        while (!out_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic expect_result(input string tag, input int cls, input logic [31:0] score);
        int l;
        wait_valid(l);
        check({tag, "_lat"}, l, 5);
        check({tag, "_class"}, out_class, cls);
        check({tag, "_score"}, out_score, score);
        tick();
        check({tag, "_idle_ready"}, in_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_coef_idx"}, coef_idx, 0);
        check({tag, "_class"}, out_class, 0);
        check({tag, "_score"}, out_score, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        set_w(0, 0);
        set_b(1, 1, 1);

        // Reset behaviour
        repeat (3) tick();
        check_reset_outputs("rst");
        rst = 1'b0;
        #1;
        check("rst_release_ready", in_ready, 1);

        // OvO, zero weights, all biases +1: walk coef_idx cycle by cycle
        send(1'b0, 0, 0);
        check("ovo1_idx0", coef_idx, 0);
        check("ovo1_valid_e0", out_valid, 0);
        tick();
        check("ovo1_idx1", coef_idx, 1);
        tick();
        check("ovo1_idx2", coef_idx, 2);
        tick();
        check("ovo1_decide_idx", coef_idx, 0);
        check("ovo1_decide_valid", out_valid, 0);
        tick();
        check("ovo1_valid", out_valid, 1);
        check("ovo1_class", out_class, 0);
        check("ovo1_score", out_score, 2);
        tick();
        check("ovo1_idle_ready", in_ready, 1);

        // OvO vote patterns
        set_b(1, -1, 1);
        send(1'b0, 0, 0);
        expect_result("ovo_tie", 0, 1);
        set_b(0, 1, -1);
        send(1'b0, 0, 0);
        expect_result("ovo_zero_pos", 0, 2);
        set_b(-1, -1, -1);
        send(1'b0, 0, 0);
        expect_result("ovo_cls2", 2, 2);
        set_b(-1, 1, 1);
        send(1'b0, 0, 0);
        expect_result("ovo_cls1", 1, 2);

        // OvR argmax
        set_w(1, 0);
        set_b(0, 5, 5);
        send(1'b1, 3, 0);
        expect_result("ovr_first_max", 1, 8);
        set_b(10, 2, -20);
        send(1'b1, 3, 0);
        expect_result("ovr_cls0", 0, 13);
        set_w(0, 0);
        set_b(-5, -3, -7);
        send(1'b1, 9, 9);
        expect_result("ovr_neg", 1, sc(-3));

        // Backpressure
        set_b(1, 1, 1);
        out_ready = 1'b0;
        send(1'b0, 0, 0);
        wait_valid(lat);
        check("bp_lat", lat, 5);
        for (int n = 0; n < 10; n++) begin
            in_valid = n[0];
            in_mode  = 1'b1;
            check("bp_valid", out_valid, 1);
            check("bp_class", out_class, 0);
            check("bp_score", out_score, 2);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_ready", in_ready, 1);
        check("bp_release_valid", out_valid, 0);
        tick();
        check("bp_no_stray_req", in_ready, 1);
        check("bp_no_stray_idx", coef_idx, 0);

        // Reset in the middle of EVAL
        set_b(1, -1, 1);
        send(1'b0, 0, 0);
        check("mid_idx0", coef_idx, 0);
        tick();
        check("mid_idx1", coef_idx, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        #1;
        check("mid_idle_ready", in_ready, 1);
        for (int n = 0; n < 6; n++) begin
            tick();
            check("mid_no_valid", out_valid, 0);
            check("mid_still_idle", in_ready, 1);
        end
        send(1'b0, 0, 0);
        expect_result("mid_rerun", 0, 1);

        // Negative extremes
        set_w(-128, -128);
        set_b(-2048, -2048, -2048);
        send(1'b1, 15, 15);
        expect_result("neg_ovr", 0, sc(-5888));
        send(1'b0, 15, 15);
        expect_result("neg_ovo", 2, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
